// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: operand compare, taken/target/mispredict resolution
// through a 1- or 2-stage valid/ready pipeline, plus retire statistics.
module branch_resolve_unit #(
   parameter int XLEN        = 32,
   parameter int PIPE_STAGES = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  rs1_value,
   input  logic [XLEN-1:0]  rs2_value,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  imm,
   input  logic             pred_taken,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [5:0]       flags,
   output logic             taken,
   output logic [XLEN-1:0]  target,
   output logic             mispredict,
   output logic             illegal,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   logic             eq, lt, ltu;
   logic [5:0]       flags_c;
   logic             xfer;
   logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

   assign eq      = (rs1_value == rs2_value);
   assign lt      = ($signed(rs1_value) < $signed(rs2_value));
   assign ltu     = (rs1_value < rs2_value);
   assign flags_c = {~ltu, ltu, ~lt, lt, ~eq, eq};

   // flag bits: 0 EQ, 1 NEQ, 2 LT, 3 GE, 4 LTU, 5 GEU
   function automatic logic take_f(input logic [2:0] f3,
                                   input logic [5:0] fl);
      logic t;
      t = 1'b0;
      case (f3)
         3'b000:  t = fl[0];
         3'b001:  t = fl[1];
         3'b100:  t = fl[2];
         3'b101:  t = fl[3];
         3'b110:  t = fl[4];
         3'b111:  t = fl[5];
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   if (PIPE_STAGES == 1) begin : g_p1
      logic            v_q, tk_q, mp_q, il_q;
      logic [5:0]      fl_q;
      logic [XLEN-1:0] tg_q;
      logic            tk_c, il_c;

      assign il_c     = (funct3[2:1] == 2'b01);
      assign tk_c     = take_f(funct3, flags_c);
      assign in_ready = !v_q || out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q  <= 1'b0;
            fl_q <= '0;
            tk_q <= 1'b0;
            tg_q <= '0;
            mp_q <= 1'b0;
            il_q <= 1'b0;
         end else if (flush) begin
            v_q <= 1'b0;
         end else if (in_ready) begin
            v_q <= in_valid;
            if (in_valid) begin
               fl_q <= flags_c;
               tk_q <= tk_c;
               tg_q <= tk_c ? pc + imm : pc + XLEN'(4);
               mp_q <= !il_c && (tk_c != pred_taken);
               il_q <= il_c;
            end
         end
      end

      assign out_valid  = v_q;
      assign flags      = fl_q;
      assign taken      = tk_q;
      assign target     = tg_q;
      assign mispredict = mp_q;
      assign illegal    = il_q;
   end else if (PIPE_STAGES == 2) begin : g_p2
      logic            v1_q, pr1_q;
      logic [2:0]      f3_q;
      logic [5:0]      fl1_q, fl2_q;
      logic [XLEN-1:0] tt_q, nt_q;
      logic            v2_q, tk_q, mp_q, il_q;
      logic [XLEN-1:0] tg_q;
      logic            adv2, tk_c, il_c;

      assign adv2     = !v2_q || out_ready;
      assign in_ready = !v1_q || adv2;
      assign il_c     = (f3_q[2:1] == 2'b01);
      assign tk_c     = take_f(f3_q, fl1_q);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v1_q  <= 1'b0;
            pr1_q <= 1'b0;
            f3_q  <= '0;
            fl1_q <= '0;
            tt_q  <= '0;
            nt_q  <= '0;
            v2_q  <= 1'b0;
            fl2_q <= '0;
            tk_q  <= 1'b0;
            tg_q  <= '0;
            mp_q  <= 1'b0;
            il_q  <= 1'b0;
         end else if (flush) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
         end else begin
            if (in_ready) begin
               v1_q <= in_valid;
               if (in_valid) begin
                  pr1_q <= pred_taken;
                  f3_q  <= funct3;
                  fl1_q <= flags_c;
                  tt_q  <= pc + imm;
                  nt_q  <= pc + XLEN'(4);
               end
            end
            if (adv2) begin
               v2_q <= v1_q;
               if (v1_q) begin
                  fl2_q <= fl1_q;
                  tk_q  <= tk_c;
                  tg_q  <= tk_c ? tt_q : nt_q;
                  mp_q  <= !il_c && (tk_c != pr1_q);
                  il_q  <= il_c;
               end
            end
         end
      end

      assign out_valid  = v2_q;
      assign flags      = fl2_q;
      assign taken      = tk_q;
      assign target     = tg_q;
      assign mispredict = mp_q;
      assign illegal    = il_q;
   end else begin : g_bad
      $error("branch_resolve_unit: PIPE_STAGES must be 1 or 2");
   end

   // flush wins over the output handshake, so a killed result never retires
   assign xfer = out_valid && out_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else if (clr_cnt) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else if (xfer) begin
         if (!illegal && branch_cnt_q != '1)
            branch_cnt_q <= branch_cnt_q + CNT_W'(1);
         if (mispredict && mispred_cnt_q != '1)
            mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
   end

   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule
